// File: rtl/fcmp_pipe.sv
// Two-stage binary32 compare/select unit with valid/ready handshake on both sides.
// Stage 1 captures operands plus magnitude/sign flags; stage 2 forms the result and holds it.
module fcmp_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res
);

  localparam logic [2:0] OP_FEQ  = 3'b000;
  localparam logic [2:0] OP_FLT  = 3'b001;
  localparam logic [2:0] OP_FLE  = 3'b010;
  localparam logic [2:0] OP_FMIN = 3'b011;
  localparam logic [2:0] OP_FMAX = 3'b100;

  logic        s1_valid;
  logic [31:0] s1_x;
  logic [31:0] s1_y;
  logic [2:0]  s1_op;
  logic        s1_mag_lt;
  logic        s1_mag_eq;
  logic        s1_sx;
  logic        s1_sy;

  logic        adv2;
  logic        accept;
  logic        lt;
  logic        eq;
  logic [31:0] res_nxt;

  assign adv2     = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | adv2;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_x      <= 32'h0;
      s1_y      <= 32'h0;
      s1_op     <= 3'b000;
      s1_mag_lt <= 1'b0;
      s1_mag_eq <= 1'b0;
      s1_sx     <= 1'b0;
      s1_sy     <= 1'b0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_x      <= x;
      s1_y      <= y;
      s1_op     <= op;
      s1_mag_lt <= x[30:0] < y[30:0];
      s1_mag_eq <= x[30:0] == y[30:0];
      s1_sx     <= x[31];
      s1_sy     <= y[31];
    end else if (adv2) begin
      s1_valid  <= 1'b0;
    end
  end

  // Sign-magnitude ordering: with both signs set, larger magnitude is smaller.
  always_comb begin
    lt      = 1'b0;
    eq      = s1_mag_eq & (s1_sx == s1_sy);
    res_nxt = 32'h0;
    case ({s1_sx, s1_sy})
      2'b10:   lt = 1'b1;
      2'b01:   lt = 1'b0;
      2'b11:   lt = ~s1_mag_lt & ~s1_mag_eq;
      default: lt = s1_mag_lt;
    endcase
    case (s1_op)
      OP_FEQ:  res_nxt = {31'b0, eq};
      OP_FLT:  res_nxt = {31'b0, lt};
      OP_FLE:  res_nxt = {31'b0, lt | eq};
      OP_FMIN: res_nxt = lt ? s1_x : s1_y;
      OP_FMAX: res_nxt = lt ? s1_y : s1_x;
      default: res_nxt = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= 32'h0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        res <= res_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe: directed cases, back-pressure, streaming and reset,
// scored against an ordering-key model of the compare rules.
module tb_fcmp_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] x;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;

  fcmp_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  logic [31:0] exp_q[$];
  logic        prev_stall;
  logic [31:0] prev_res;
  int          cyc;
  int          first_out;
  int          last_out;
  int          n_out;
  int          first_block;
  int          n_acc;
  logic [2:0]  tx_op[33];
  logic [31:0] tx_x[33];
  logic [31:0] tx_y[33];

  // Map a bit pattern onto a signed integer whose natural order is the compare order;
  // negatives are shifted down by one so that -0 sorts strictly below +0.
  function automatic longint order_key(input logic [31:0] v);
    longint mag;
    mag = longint'(v[30:0]);
    return v[31] ? (-mag - 1) : mag;
  endfunction

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit m_lt;
    bit m_eq;
    m_lt = order_key(a) < order_key(b);
    m_eq = (a == b);
    case (o)
      3'd0:    return {31'b0, m_eq};
      3'd1:    return {31'b0, m_lt};
      3'd2:    return {31'b0, m_lt | m_eq};
      3'd3:    return m_lt ? a : b;
      3'd4:    return m_lt ? b : a;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: drive inputs just after a rising edge, sample at the falling edge.
  task automatic cycle(input logic iv, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, output logic acc);
    in_valid  = iv;
    op        = o;
    x         = a;
    y         = b;
    out_ready = ordy;
    @(negedge clk);
    if (prev_stall) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_res", res, prev_res);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        chk("res", res, exp_q.pop_front());
        n_out++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
    end
    if (!in_ready && first_block < 0) first_block = cyc;
    acc = iv && in_ready;
    if (acc) exp_q.push_back(model(o, a, b));
    prev_stall = out_valid && !out_ready;
    prev_res   = res;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_stream(input int n, input int stall);
    int   idx;
    logic acc;
    int   j;
    idx = 0;
    cyc = 0;
    first_out = -1;
    last_out = -1;
    n_out = 0;
    first_block = -1;
    for (int k = 0; k < 300; k++) begin
      if (idx == n && exp_q.size() == 0) break;
      j = (idx < n) ? idx : 0;
      cycle(idx < n, tx_op[j], tx_x[j], tx_y[j], cyc >= stall, acc);
      if (acc) idx++;
    end
    n_acc = idx;
    chk("all_accepted", 32'(idx), 32'(n));
    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("idle_after", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic single(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    tx_op[0] = o;
    tx_x[0]  = a;
    tx_y[0]  = b;
    run_stream(1, 0);
  endtask

  initial begin
    logic acc;
    logic [31:0] r;
    rst = 1'b1;
    in_valid = 1'b0;
    op = 3'b000;
    x = 32'h0;
    y = 32'h0;
    out_ready = 1'b0;
    prev_stall = 1'b0;
    prev_res = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_res", res, 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // directed cases
    single(3'd1, 32'h3F800000, 32'h40000000);
    chk("latency", 32'(first_out), 32'd2);
    single(3'd1, 32'h40000000, 32'h3F800000);
    single(3'd1, 32'hBF800000, 32'hC0000000);
    single(3'd2, 32'hC0000000, 32'hBF800000);
    single(3'd4, 32'hC0000000, 32'hBF800000);
    single(3'd1, 32'h80000000, 32'h00000000);
    single(3'd0, 32'h80000000, 32'h00000000);
    single(3'd3, 32'h80000000, 32'h00000000);
    single(3'd0, 32'h3F800000, 32'h3F800000);
    single(3'd5, 32'h3F800000, 32'h40000000);
    chk("known_fmin_negzero", model(3'd3, 32'h80000000, 32'h0), 32'h80000000);

    // back-pressure: four flt, consumer stalled for three cycles
    tx_op[0] = 3'd1; tx_x[0] = 32'h3F800000; tx_y[0] = 32'h40000000;
    tx_op[1] = 3'd1; tx_x[1] = 32'h40000000; tx_y[1] = 32'h3F800000;
    tx_op[2] = 3'd1; tx_x[2] = 32'hBF800000; tx_y[2] = 32'hC0000000;
    tx_op[3] = 3'd1; tx_x[3] = 32'h80000000; tx_y[3] = 32'h00000000;
    run_stream(4, 3);
    chk("bp_first_block", 32'(first_block), 32'd2);
    chk("bp_outputs", 32'(n_out), 32'd4);

    // full-throughput random streaming
    for (int i = 0; i < 16; i++) begin
      tx_op[i] = 3'($urandom_range(0, 7));
      tx_x[i]  = $urandom;
      r = $urandom;
      case (i % 4)
        0:       tx_y[i] = tx_x[i];
        1:       tx_y[i] = tx_x[i] ^ 32'h80000000;
        default: tx_y[i] = r;
      endcase
    end
    run_stream(16, 0);
    chk("stream_first", 32'(first_out), 32'd2);
    chk("stream_span", 32'(last_out - first_out), 32'd15);
    chk("stream_count", 32'(n_out), 32'd16);

    // reset with two transactions in flight
    cycle(1'b1, 3'd1, 32'h3F800000, 32'h40000000, 1'b0, acc);
    cycle(1'b1, 3'd1, 32'h40000000, 32'h3F800000, 1'b0, acc);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_res", res, 32'h0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    single(3'd1, 32'h3F800000, 32'h40000000);
    chk("post_reset_latency", 32'(first_out), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
